// File: rtl/full_subtractor_pkg.sv
// Shared bit-level equations for the ripple-borrow subtractor.
package full_subtractor_pkg;

    function automatic logic cell_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow when the minuend bit is 0 against a 1, or the bits tie and a borrow arrives.
    function automatic logic cell_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full subtractor cell.
module full_subtractor_bit
    import full_subtractor_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = cell_diff(a_i, b_i, bin_i);
    assign bout_o = cell_borrow(a_i, b_i, bin_i);

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor Diff = A - B - Bin with optional registered output stage.
module full_subtractor #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             out_valid
);

    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff_d;

    assign borrow_chain[0] = Bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_bit u_bit (
            .a_i    (A[i]),
            .b_i    (B[i]),
            .bin_i  (borrow_chain[i]),
            .d_o    (diff_d[i]),
            .bout_o (borrow_chain[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] diff_q;
        logic             borrow_q;
        logic             valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                diff_q   <= '0;
                borrow_q <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                valid_q <= in_valid;
                // Result holds across idle cycles; only out_valid tracks in_valid.
                if (in_valid) begin
                    diff_q   <= diff_d;
                    borrow_q <= borrow_chain[WIDTH];
                end
            end
        end

        assign Diff      = diff_q;
        assign Borrow    = borrow_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        assign Diff      = diff_d;
        assign Borrow    = borrow_chain[WIDTH];
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench: 1-bit and 8-bit registered instances plus an 8-bit combinational one.
module tb_full_subtractor;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic d;
        logic bo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, bin, in_valid;
    logic [7:0] a8, b8;

    logic       d1, bo1, ov1;
    logic [7:0] d8, d8c;
    logic       bo8, ov8, bo8c, ov8c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Bin(bin), .in_valid(in_valid),
        .Diff(d1), .Borrow(bo1), .out_valid(ov1)
    );

    full_subtractor #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Bin(bin), .in_valid(in_valid),
        .Diff(d8), .Borrow(bo8), .out_valid(ov8)
    );

    full_subtractor #(.WIDTH(8), .REG_OUT(1'b0)) u_dut8c (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Bin(bin), .in_valid(in_valid),
        .Diff(d8c), .Borrow(bo8c), .out_valid(ov8c)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] ea, input logic [7:0] eb,
                          input logic ebin, input logic [7:0] exp_d, input logic exp_bo);
        @(negedge clk);
        a8 = ea; b8 = eb; bin = ebin; in_valid = 1'b1;
        #1;
        check({name, " comb diff"}, {8'h0, d8c}, {8'h0, exp_d});
        check({name, " comb borrow"}, {15'h0, bo8c}, {15'h0, exp_bo});
        edge_sample();
        check({name, " reg diff"}, {8'h0, d8}, {8'h0, exp_d});
        check({name, " reg borrow"}, {15'h0, bo8}, {15'h0, exp_bo});
        check({name, " reg valid"}, {15'h0, ov8}, 16'h1);
    endtask

    initial begin
        vec_t       tbl[8];
        logic [8:0] ref9;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; bin = 1'b0;
        a8 = 8'h0; b8 = 8'h0;
        edge_sample();
        edge_sample();
        check("reset diff8", {8'h0, d8}, 16'h0);
        check("reset valid8", {15'h0, ov8}, 16'h0);

        // Reset must win over a simultaneous valid operand.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; bin = 1'b1; in_valid = 1'b1;
        edge_sample();
        check("rst+valid diff", {15'h0, d1}, 16'h0);
        check("rst+valid borrow", {15'h0, bo1}, 16'h0);
        check("rst+valid out_valid", {15'h0, ov1}, 16'h0);
        edge_sample();
        check("rst held out_valid", {15'h0, ov1}, 16'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = tbl[i].a; b1 = tbl[i].b; bin = tbl[i].bin; in_valid = 1'b1;
            edge_sample();
            check($sformatf("tt%0d diff", i), {15'h0, d1}, {15'h0, tbl[i].d});
            check($sformatf("tt%0d borrow", i), {15'h0, bo1}, {15'h0, tbl[i].bo});
            check($sformatf("tt%0d valid", i), {15'h0, ov1}, 16'h1);
        end

        // Hold: result stays when in_valid drops.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; bin = 1'b0; in_valid = 1'b1;
        edge_sample();
        check("hold load diff", {15'h0, d1}, 16'h1);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; bin = 1'b1; in_valid = 1'b0;
        #1;
        check("comb valid follows", {15'h0, ov8c}, 16'h0);
        edge_sample();
        check("hold diff", {15'h0, d1}, 16'h1);
        check("hold borrow", {15'h0, bo1}, 16'h0);
        check("hold out_valid", {15'h0, ov1}, 16'h0);

        check8("wrap", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        check8("normal", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        check8("eq bin0", 8'hA7, 8'hA7, 1'b0, 8'h00, 1'b0);
        check8("eq bin1", 8'hA7, 8'hA7, 1'b1, 8'hFF, 1'b1);
        check8("max", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

        // Mid-stream reset discards the in-flight result.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin = 1'b0; in_valid = 1'b1; rst = 1'b1;
        edge_sample();
        check("midrst diff", {8'h0, d8}, 16'h0);
        check("midrst valid", {15'h0, ov8}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        check("post rst first", {8'h0, d8}, 16'h0F);
        check("post rst valid", {15'h0, ov8}, 16'h1);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rbin = 1'($urandom_range(1));
            ref9 = {1'b0, ra} - {1'b0, rb} - {8'h0, rbin};
            check8($sformatf("rnd%0d", i), ra, rb, rbin, ref9[7:0], ref9[8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
